// File: rtl/am4_useq_pkg.sv
// Shared definitions for the am4_useq microprogram sequencer and the microword
// field layouts that feed it: next-address op codes and default widths.
package am4_useq_pkg;

    localparam int DEF_AW = 9;
    localparam int DEF_SD = 4;
    localparam int DEF_CW = 8;
    localparam int MAP_W  = 7;

    localparam logic [2:0] OP_CONT = 3'd0;
    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_CJMP = 3'd2;
    localparam logic [2:0] OP_MAP  = 3'd3;
    localparam logic [2:0] OP_JSR  = 3'd4;
    localparam logic [2:0] OP_RTS  = 3'd5;
    localparam logic [2:0] OP_LOOP = 3'd6;
    localparam logic [2:0] OP_LDCT = 3'd7;

    // The pointer counts 0..depth inclusive, so it needs one more code than the depth.
    function automatic int sp_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/am4_useq_stack.sv
// Parameterised LIFO holding subroutine return addresses. Pushes when full and
// pops when empty are silently dropped; the parent decides what that means.
module am4_useq_stack
    import am4_useq_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int SD = DEF_SD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int PW = sp_width(SD);
    localparam int IW = (SD > 1) ? $clog2(SD) : 1;

    logic [PW-1:0] sp;
    logic [PW-1:0] top;
    logic [AW-1:0] mem [SD];

    assign full  = (sp == PW'(SD));
    assign empty = (sp == '0);
    assign top   = sp - PW'(1);
    assign dout  = empty ? '0 : mem[IW'(top)];

    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + PW'(1);
        end else if (pop && !empty) begin
            sp <= top;
        end
    end

    // Storage needs no reset: an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (!rst && push && !full) begin
            mem[IW'(sp)] <= din;
        end
    end

endmodule

// File: rtl/am4_useq.sv
// Am2909/2911-style microprogram sequencer sitting behind the PDP-11 decode PLM;
// ua is registered and drives the microcode ROM address directly.
module am4_useq
    import am4_useq_pkg::*;
#(
    parameter int            AW       = DEF_AW,
    parameter int            SD       = DEF_SD,
    parameter int            CW       = DEF_CW,
    parameter logic [AW-1:0] RST_ADDR = '0,
    parameter logic [AW-1:0] MAP_BASE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [2:0]       mop,
    input  logic             cc,
    input  logic [AW-1:0]    d,
    input  logic [MAP_W-1:0] map_ad,
    input  logic             map_bf,
    output logic [AW-1:0]    ua,
    output logic             bf,
    output logic             stk_ovf,
    output logic             stk_unf
);

    logic [AW-1:0] inc;
    logic [AW-1:0] nxt_ua;
    logic          nxt_bf;
    logic [CW-1:0] cnt;
    logic [CW-1:0] nxt_cnt;
    logic          push;
    logic          pop;
    logic          set_ovf;
    logic          set_unf;
    logic [AW-1:0] stk_dout;
    logic          stk_full;
    logic          stk_empty;

    assign inc = ua + AW'(1);

    am4_useq_stack #(
        .AW (AW),
        .SD (SD)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (ce & push),
        .pop   (ce & pop),
        .din   (inc),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Next-address mux; stack misuse falls back to a harmless address and sets a flag.
    always_comb begin
        nxt_ua  = inc;
        nxt_bf  = bf;
        nxt_cnt = cnt;
        push    = 1'b0;
        pop     = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        case (mop)
            OP_CONT: begin
            end
            OP_JMP: begin
                nxt_ua = d;
            end
            OP_CJMP: begin
                if (cc) begin
                    nxt_ua = d;
                end
            end
            OP_MAP: begin
                nxt_ua = MAP_BASE | AW'(map_ad);
                nxt_bf = map_bf;
            end
            OP_JSR: begin
                nxt_ua = d;
                if (stk_full) begin
                    set_ovf = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end
            OP_RTS: begin
                if (stk_empty) begin
                    set_unf = 1'b1;
                end else begin
                    pop    = 1'b1;
                    nxt_ua = stk_dout;
                end
            end
            OP_LOOP: begin
                if (cnt != '0) begin
                    nxt_cnt = cnt - CW'(1);
                    nxt_ua  = d;
                end
            end
            OP_LDCT: begin
                nxt_cnt = d[CW-1:0];
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ua      <= RST_ADDR;
            bf      <= 1'b0;
            cnt     <= '0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else if (ce) begin
            ua      <= nxt_ua;
            bf      <= nxt_bf;
            cnt     <= nxt_cnt;
            stk_ovf <= stk_ovf | set_ovf;
            stk_unf <= stk_unf | set_unf;
        end
    end

endmodule

// File: tb/tb_am4_useq.sv
// Directed bench for am4_useq: each step pushes its expected outputs onto a
// scoreboard, and the entry is popped and compared one clock later.
module tb_am4_useq;
    import am4_useq_pkg::*;

    logic       clk;
    logic       rst;
    logic       ce;
    logic [2:0] mop;
    logic       cc;
    logic [8:0] d;
    logic [6:0] map_ad;
    logic       map_bf;
    logic [8:0] ua;
    logic       bf;
    logic       stk_ovf;
    logic       stk_unf;

    typedef struct packed {
        logic [8:0] ua;
        logic       bf;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    am4_useq #(
        .AW       (9),
        .SD       (4),
        .CW       (8),
        .RST_ADDR (9'h000),
        .MAP_BASE (9'h100)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .mop     (mop),
        .cc      (cc),
        .d       (d),
        .map_ad  (map_ad),
        .map_bf  (map_bf),
        .ua      (ua),
        .bf      (bf),
        .stk_ovf (stk_ovf),
        .stk_unf (stk_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL %s scoreboard empty", tag);
        end else begin
            e = sbq.pop_front();
            total++;
            assert (ua === e.ua) else begin
                bad++;
                $error("[TB] FAIL %s ua observed=%h expected=%h", tag, ua, e.ua);
            end
            total++;
            assert (bf === e.bf) else begin
                bad++;
                $error("[TB] FAIL %s bf observed=%b expected=%b", tag, bf, e.bf);
            end
            total++;
            assert (stk_ovf === e.ovf) else begin
                bad++;
                $error("[TB] FAIL %s stk_ovf observed=%b expected=%b", tag, stk_ovf, e.ovf);
            end
            total++;
            assert (stk_unf === e.unf) else begin
                bad++;
                $error("[TB] FAIL %s stk_unf observed=%b expected=%b", tag, stk_unf, e.unf);
            end
        end
    endtask

    // Drive one microcycle, record what must appear after the edge, then check it.
    task automatic applyStimulus(
        input logic       r,
        input logic       e,
        input logic [2:0] op,
        input logic       c,
        input logic [8:0] dd,
        input logic [6:0] ma,
        input logic       mb,
        input logic [8:0] eua,
        input logic       ebf,
        input logic       eovf,
        input logic       eunf,
        input string      tag
    );
        exp_t x;
        rst    = r;
        ce     = e;
        mop    = op;
        cc     = c;
        d      = dd;
        map_ad = ma;
        map_bf = mb;
        x.ua   = eua;
        x.bf   = ebf;
        x.ovf  = eovf;
        x.unf  = eunf;
        sbq.push_back(x);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; ce = 1'b1; mop = OP_CONT; cc = 1'b0; d = '0; map_ad = '0; map_bf = 1'b0;

        applyStimulus(1, 1, OP_CONT, 0, 9'h000, 7'h00, 0, 9'h000, 0, 0, 0, "reset");
        applyStimulus(0, 1, OP_CONT, 0, 9'h000, 7'h00, 0, 9'h001, 0, 0, 0, "cont1");
        applyStimulus(0, 1, OP_CONT, 0, 9'h000, 7'h00, 0, 9'h002, 0, 0, 0, "cont2");
        applyStimulus(0, 1, OP_CONT, 0, 9'h000, 7'h00, 0, 9'h003, 0, 0, 0, "cont3");
        applyStimulus(0, 0, OP_JMP,  1, 9'h1AA, 7'h00, 0, 9'h003, 0, 0, 0, "hold1");
        applyStimulus(0, 0, OP_LDCT, 1, 9'h1AA, 7'h00, 0, 9'h003, 0, 0, 0, "hold2");
        applyStimulus(1, 0, OP_JMP,  0, 9'h1AA, 7'h00, 0, 9'h000, 0, 0, 0, "rst_ce0");

        applyStimulus(0, 1, OP_JMP,  0, 9'h1FF, 7'h00, 0, 9'h1FF, 0, 0, 0, "jmp_1ff");
        applyStimulus(0, 1, OP_CONT, 0, 9'h000, 7'h00, 0, 9'h000, 0, 0, 0, "wrap");
        applyStimulus(0, 1, OP_CJMP, 0, 9'h050, 7'h00, 0, 9'h001, 0, 0, 0, "cjmp_cc0");
        applyStimulus(0, 1, OP_CJMP, 1, 9'h050, 7'h00, 0, 9'h050, 0, 0, 0, "cjmp_cc1");

        applyStimulus(0, 1, OP_MAP,  0, 9'h000, 7'h47, 1, 9'h147, 1, 0, 0, "map_47");
        applyStimulus(0, 1, OP_JMP,  0, 9'h1AA, 7'h00, 0, 9'h1AA, 1, 0, 0, "jmp_keeps_bf");
        applyStimulus(0, 1, OP_MAP,  0, 9'h000, 7'h01, 0, 9'h101, 0, 0, 0, "map_01");
        applyStimulus(0, 1, OP_JMP,  0, 9'h010, 7'h00, 1, 9'h010, 0, 0, 0, "jmp_010");
        applyStimulus(0, 0, OP_MAP,  0, 9'h000, 7'h7F, 1, 9'h010, 0, 0, 0, "map_ce0");

        applyStimulus(0, 1, OP_JSR,  0, 9'h020, 7'h00, 0, 9'h020, 0, 0, 0, "jsr_20");
        applyStimulus(0, 1, OP_JSR,  0, 9'h030, 7'h00, 0, 9'h030, 0, 0, 0, "jsr_30");
        applyStimulus(0, 1, OP_JSR,  0, 9'h040, 7'h00, 0, 9'h040, 0, 0, 0, "jsr_40");
        applyStimulus(0, 1, OP_JSR,  0, 9'h050, 7'h00, 0, 9'h050, 0, 0, 0, "jsr_50");
        applyStimulus(0, 1, OP_JSR,  0, 9'h060, 7'h00, 0, 9'h060, 0, 1, 0, "jsr_ovf");
        applyStimulus(0, 1, OP_RTS,  0, 9'h1AA, 7'h00, 0, 9'h041, 0, 1, 0, "rts_41");
        applyStimulus(0, 1, OP_RTS,  0, 9'h1AA, 7'h00, 0, 9'h031, 0, 1, 0, "rts_31");
        applyStimulus(0, 1, OP_RTS,  0, 9'h1AA, 7'h00, 0, 9'h021, 0, 1, 0, "rts_21");
        applyStimulus(0, 1, OP_RTS,  0, 9'h1AA, 7'h00, 0, 9'h011, 0, 1, 0, "rts_11");
        applyStimulus(0, 1, OP_RTS,  0, 9'h1AA, 7'h00, 0, 9'h012, 0, 1, 1, "rts_unf");

        applyStimulus(0, 1, OP_JMP,  0, 9'h005, 7'h00, 0, 9'h005, 0, 1, 1, "jmp_05");
        applyStimulus(0, 1, OP_LDCT, 0, 9'h002, 7'h00, 0, 9'h006, 0, 1, 1, "ldct_2");
        applyStimulus(0, 1, OP_CONT, 0, 9'h000, 7'h00, 0, 9'h007, 0, 1, 1, "body1");
        applyStimulus(0, 1, OP_LOOP, 0, 9'h006, 7'h00, 0, 9'h006, 0, 1, 1, "loop1");
        applyStimulus(0, 1, OP_CONT, 0, 9'h000, 7'h00, 0, 9'h007, 0, 1, 1, "body2");
        applyStimulus(0, 1, OP_LOOP, 0, 9'h006, 7'h00, 0, 9'h006, 0, 1, 1, "loop2");
        applyStimulus(0, 1, OP_CONT, 0, 9'h000, 7'h00, 0, 9'h007, 0, 1, 1, "body3");
        applyStimulus(0, 1, OP_LOOP, 0, 9'h006, 7'h00, 0, 9'h008, 0, 1, 1, "loop_exit");

        applyStimulus(0, 1, OP_LDCT, 0, 9'h001, 7'h00, 0, 9'h009, 0, 1, 1, "ldct_1");
        applyStimulus(0, 1, OP_JSR,  0, 9'h020, 7'h00, 0, 9'h020, 0, 1, 1, "jsr_a");
        applyStimulus(0, 1, OP_JSR,  0, 9'h030, 7'h00, 0, 9'h030, 0, 1, 1, "jsr_b");
        applyStimulus(1, 1, OP_JSR,  0, 9'h0AA, 7'h00, 0, 9'h000, 0, 0, 0, "rst_mid");
        applyStimulus(0, 1, OP_RTS,  0, 9'h0AA, 7'h00, 0, 9'h001, 0, 0, 1, "rts_after_rst");
        applyStimulus(0, 1, OP_LOOP, 0, 9'h0AA, 7'h00, 0, 9'h002, 0, 0, 1, "loop_after_rst");

        applyStimulus(0, 1, OP_JSR,  0, 9'h040, 7'h00, 0, 9'h040, 0, 0, 1, "jsr_c");
        applyStimulus(0, 1, OP_LDCT, 0, 9'h005, 7'h00, 0, 9'h041, 0, 0, 1, "ldct_keeps_stack");
        applyStimulus(0, 1, OP_RTS,  0, 9'h0AA, 7'h00, 0, 9'h003, 0, 0, 1, "rts_c");
        applyStimulus(0, 1, OP_LOOP, 0, 9'h070, 7'h00, 0, 9'h070, 0, 0, 1, "loop_cnt5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/am4_useq.md
Name: am4_useq

Overview:
- Microprogram sequencer directly downstream of the PDP-11 instruction decode PLM.
- Consumes the PLM's 7-bit microcode entry address and byte-operation flag on a MAP operation.
- Produces the registered microaddress that drives the microcode ROM.
- Am2909/2911-style: µPC increment, direct jump, conditional jump, subroutine stack, loop counter.

Parameters:
- AW, 9: microaddress width (must be ≥ 7).
- SD, 4: subroutine stack depth, in entries.
- CW, 8: loop counter width (must be ≤ AW).
- RST_ADDR, 0: microaddress after reset.
- MAP_BASE, 0: AW-bit base OR-ed with the zero-extended map address.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- ce  in  1  microcycle enable; state advances only when high
- mop  in  3  next-address operation from the current microword
- cc  in  1  condition input for CJMP
- d  in  AW  direct address / literal field from the microword
- map_ad  in  7  microcode entry address from the decode PLM
- map_bf  in  1  byte-operation flag from the decode PLM
- ua  out  AW  current microaddress (registered)
- bf  out  1  latched byte-operation flag for the current instruction
- stk_ovf  out  1  sticky stack-overflow flag
- stk_unf  out  1  sticky stack-underflow flag

Behaviour:
- Reset: one clock with clk and rst both high. Synchronous, active-high, overrides ce. Values after reset:
  - ua = RST_ADDR
  - bf = 0
  - stack pointer sp = 0 (empty)
  - loop counter cnt = 0
  - stk_ovf = 0, stk_unf = 0
  - Reset mid-subroutine or mid-loop discards all stack and counter state.
- ce = 0: all registers hold; mop, cc, d and map inputs are ignored.
- Latency: with ce = 1, the operation presented in cycle n determines ua after edge n. ua is a registered output with no combinational path from the inputs.
- inc = ua + 1, modulo 2^AW (wraps from all-ones to 0).
- mop encoding:
  - 0 CONT: ua <= inc.
  - 1 JMP: ua <= d.
  - 2 CJMP: ua <= cc ? d : inc.
  - 3 MAP: ua <= MAP_BASE | {0, map_ad}; bf <= map_bf. MAP is the only op that writes bf.
  - 4 JSR: push inc; ua <= d.
  - 5 RTS: pop; ua <= popped value.
  - 6 LOOP: if cnt != 0 then cnt <= cnt - 1 and ua <= d; else ua <= inc.
  - 7 LDCT: cnt <= d[CW-1:0]; ua <= inc.
- Loop count: LDCT with value N followed by LOOP executes the loop body N+1 times in total.
- Stack: LIFO of SD entries, AW bits each. sp ranges 0..SD; its width is clog2(SD+1).
  - JSR with sp = SD: jump still taken; return address dropped; sp unchanged; stk_ovf <= 1.
  - RTS with sp = 0: ua <= inc; sp unchanged; stk_unf <= 1.
  - stk_ovf and stk_unf are sticky and clear only on rst.
- cnt is untouched by every op except LDCT and LOOP. The stack is untouched by every op except JSR and RTS.

Decomposition:
- Shared package am4_useq_pkg:
  - localparams for the eight mop codes (OP_CONT … OP_LDCT)
  - default widths AW, SD, CW
  - the package is also imported by the microword field definitions.
- One sub-module, am4_useq_stack: a parameterised LIFO.
  - Inputs: push, pop, din.
  - Outputs: dout, full, empty.
  - Same clk/rst convention as am4_useq.
  - A push when full and a pop when empty are ignored inside the sub-module; the error flags live in the parent.
- The next-address multiplexer and the loop counter stay in am4_useq.

Test Plan:
- Reset, then CONT ×3 with ce = 1 → ua = 0, 1, 2, 3. Then hold ce = 0 for 2 cycles → ua stays 3. Then assert rst with ce = 0 → ua = 0.
- JMP d = 9'h1FF, then CONT → ua = 1FF, then 000 (wrap). CJMP d = 9'h050 with cc = 0 → ua = 001. CJMP d = 9'h050 with cc = 1 → ua = 050.
- MAP with map_ad = 7'h47, map_bf = 1 and MAP_BASE = 9'h100 → ua = 147, bf = 1. A following JMP leaves bf = 1. MAP with map_ad = 7'h01, map_bf = 0 → ua = 101, bf = 0.
- From ua = 10, JSR to 20, then 30, 40, 50 (stack full) → stack holds 11/21/31/41. JSR at 50 to 60 → ua = 60, stk_ovf = 1. RTS ×4 → ua = 41, 31, 21, 11. A 5th RTS → ua = 12, stk_unf = 1.
- At ua = 5: LDCT d = 2 → ua = 6. Body CONT at 6, then LOOP d = 6 at 7, repeated → ua sequence 6, 7, 6, 7, 6, 7, 8; loop body executes 3 times; cnt ends at 0.
- Mid-loop (cnt = 1) with 2 stack entries pushed, assert rst for one cycle → ua = RST_ADDR, flags 0. A following RTS sets stk_unf and gives ua = 1. A following LOOP falls through.
